ram_fifo_ctrl: RTL and testbench

- FIFO controller wrapped around the team's 64x8 single-port RAM.
- The RAM has a registered read address and a combinational q from the registered address.
- This block sits directly in front of the RAM: it drives data/addr/we and consumes q.
- It presents valid/ready push and pop interfaces to the surrounding datapath.
- One RAM access per cycle. Reads are arbitrated over writes. A one-entry output register holds the head word.

---
 rtl/ram_fifo_ctrl_if.sv | 26 ++
 rtl/ram_fifo_ctrl.sv | 108 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: push/pop valid-ready handshake bundle for ram_fifo_ctrl.
//   push_valid/push_data  producer -> FIFO
//   push_ready            FIFO -> producer
//   pop_valid/pop_data    FIFO -> consumer (pop_data is registered)
//   pop_ready             consumer -> FIFO
// master = the surrounding datapath, slave = the FIFO controller.
interface ram_fifo_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              push_valid;
    logic [DATA_W-1:0] push_data;
    logic              push_ready;
    logic              pop_valid;
    logic [DATA_W-1:0] pop_data;
    logic              pop_ready;

    modport master (
        output push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data
    );

    modport slave (
        input  push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller in front of a single-port RAM with a
// registered read address and combinational q. One RAM access per cycle,
// reads win over writes, and a one-entry output register holds the head.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   fifo         push/pop handshake (ram_fifo_ctrl_if.slave)
//   ram_data     RAM write data (always push_data)
//   ram_addr     RAM address (holds last value when idle)
//   ram_we       RAM write enable
//   ram_q        RAM read data, valid the cycle after the read address
//   level        words held (RAM + output register), 0..DEPTH+1
//   full         RAM holds DEPTH words
//   empty        level == 0
//
// Optional: define RAM_FIFO_BYPASS_EN to let a push into an empty FIFO load
// the output register directly (1-cycle push-to-pop latency).
module ram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    ram_fifo_ctrl_if.slave      fifo,
    output logic [DATA_W-1:0]   ram_data,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_we,
    input  logic [DATA_W-1:0]   ram_q,
    output logic [ADDR_W:0]     level,
    output logic                full,
    output logic                empty
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, addr_hold;
    logic [ADDR_W:0]   ram_cnt;
    logic              head_free, rd_issue, push_fire, bypass, wr_fire, capture;

    // Head register can take a new word this cycle.
    assign head_free = !fifo.pop_valid || fifo.pop_ready;
    assign rd_issue  = (state == IDLE) && (ram_cnt != '0) && head_free;
    // Reads own the RAM port in rd_issue cycles, so pushes stall there.
    assign fifo.push_ready = (ram_cnt < DEPTH_C) && !rd_issue;
    assign push_fire = fifo.push_valid && fifo.push_ready;

`ifdef RAM_FIFO_BYPASS_EN
    assign bypass = push_fire && (state == IDLE) && (ram_cnt == '0) && head_free;
`else
    assign bypass = 1'b0;
`endif

    assign wr_fire  = push_fire && !bypass;
    // RD_WAIT always captures: the address was registered by the RAM last edge.
    assign capture  = (state == RD_WAIT);

    assign ram_we   = wr_fire;
    assign ram_data = fifo.push_data;
    assign ram_addr = rd_issue ? rd_ptr : (wr_fire ? wr_ptr : addr_hold);

    assign level = ram_cnt + {{ADDR_W{1'b0}}, fifo.pop_valid};
    assign full  = (ram_cnt == DEPTH_C);
    assign empty = (level == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            addr_hold     <= '0;
            ram_cnt       <= '0;
            fifo.pop_valid <= 1'b0;
            fifo.pop_data  <= '0;
        end else begin
            addr_hold <= ram_addr;
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;

            // Count drops only at capture so an in-flight slot is never reused.
            case ({wr_fire, capture})
                2'b10:   ram_cnt <= ram_cnt + 1'b1;
                2'b01:   ram_cnt <= ram_cnt - 1'b1;
                default: ram_cnt <= ram_cnt;
            endcase

            case (state)
                IDLE: begin
                    if (bypass) begin
                        fifo.pop_data  <= fifo.push_data;
                        fifo.pop_valid <= 1'b1;
                    end else if (fifo.pop_valid && fifo.pop_ready) begin
                        fifo.pop_valid <= 1'b0;
                    end
                    if (rd_issue) state <= RD_WAIT;
                end
                RD_WAIT: begin
                    fifo.pop_data  <= ram_q;
                    fifo.pop_valid <= 1'b1;
                    rd_ptr         <= rd_ptr + 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
module tb_ram_fifo_ctrl;
    localparam int DW = 8;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.DATA_W(DW)) fifo ();
    logic [DW-1:0] ram_data, ram_q;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [AW:0]   level;
    logic          full, empty;

    ram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .fifo(fifo),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q),
        .level(level), .full(full), .empty(empty)
    );

    // 64x8 RAM: registered address, combinational q.
    logic [DW-1:0] mem [64];
    logic [AW-1:0] ra;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ra <= ram_addr;
    end
    assign ram_q = mem[ra];

    int compared = 0, mismatched = 0, pops = 0;
    logic [DW-1:0] sb[$];
    bit pushed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Scoreboard bookkeeping at the sample point, then advance one cycle.
    task automatic adv();
        logic [DW-1:0] e;
        chk("level", 32'(level), 32'(sb.size()));
        chk("empty", 32'(empty), 32'(sb.size() == 0));
        if (fifo.pop_valid && fifo.pop_ready) begin
            if (sb.size() == 0) chk("pop_unexpected", 32'(fifo.pop_valid), 32'd0);
            else begin
                e = sb.pop_front();
                chk("pop_data", 32'(fifo.pop_data), 32'(e));
                pops++;
            end
        end
        pushed = fifo.push_valid && fifo.push_ready;
        if (pushed) sb.push_back(fifo.push_data);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    initial begin
        int n, np, p0, cnt;
        bit in_rd, rdi;
        fifo.push_valid = 1'b0;
        fifo.push_data  = '0;
        fifo.pop_ready  = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_pop_valid", 32'(fifo.pop_valid), 32'd0);
        chk("rst_pop_data", 32'(fifo.pop_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

`ifndef RAM_FIFO_BYPASS_EN
        // Single word through the RAM: write c0, read c1, pop_valid c3.
        fifo.push_valid = 1'b1; fifo.push_data = 8'hA5;
        settle();
        chk("c0_push_ready", 32'(fifo.push_ready), 32'd1);
        chk("c0_we", 32'(ram_we), 32'd1);
        chk("c0_addr", 32'(ram_addr), 32'd0);
        chk("c0_data", 32'(ram_data), 32'hA5);
        adv();
        fifo.push_valid = 1'b0;
        settle();
        chk("c1_we", 32'(ram_we), 32'd0);
        chk("c1_addr", 32'(ram_addr), 32'd0);
        chk("c1_push_ready", 32'(fifo.push_ready), 32'd0);
        adv();
        settle();
        chk("c2_pop_valid", 32'(fifo.pop_valid), 32'd0);
        adv();
        settle();
        chk("c3_pop_valid", 32'(fifo.pop_valid), 32'd1);
        chk("c3_pop_data", 32'(fifo.pop_data), 32'hA5);
        chk("c3_level", 32'(level), 32'd1);
        adv();
`else
        fifo.push_valid = 1'b1; fifo.push_data = 8'h3C;
        settle();
        chk("byp_c0_we", 32'(ram_we), 32'd0);
        adv();
        fifo.push_valid = 1'b0;
        settle();
        chk("byp_c1_pop_valid", 32'(fifo.pop_valid), 32'd1);
        chk("byp_c1_pop_data", 32'(fifo.pop_data), 32'h3C);
        chk("byp_c1_we", 32'(ram_we), 32'd0);
        adv();
`endif
        fifo.pop_ready = 1'b1;
        cyc();
        fifo.pop_ready = 1'b0;
        settle();
        chk("single_popped", 32'(fifo.pop_valid), 32'd0);
        adv();

        // Fill: 64 words in RAM plus one in the output register.
        fifo.push_valid = 1'b1; fifo.push_data = 8'h00;
        for (int i = 0; i < 400 && level != 7'd65; i++) begin
            cyc();
            if (pushed) fifo.push_data = fifo.push_data + 1'b1;
        end
        settle();
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_push_ready", 32'(fifo.push_ready), 32'd0);
        chk("fill_level", 32'(level), 32'd65);
        adv();
        for (int i = 0; i < 3; i++) cyc();
        settle();
        chk("full_hold_level", 32'(level), 32'd65);
        adv();
        fifo.push_valid = 1'b0;

        // Drain at one word per two cycles; rd_ptr wraps along the way.
        fifo.pop_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            settle();
            if (empty) break;
            adv();
            n++;
        end
        chk("drain_cycles", 32'(n), 32'd129);
        chk("drain_full", 32'(full), 32'd0);
        adv();

        // Streaming: push_ready must drop exactly in read-issue cycles.
        np = 0; in_rd = 1'b0;
        fifo.push_valid = 1'b1;
        for (int i = 0; i < 2000 && np < 200; i++) begin
            fifo.push_data = DW'($urandom);
            settle();
            cnt = sb.size() - int'(fifo.pop_valid);
            rdi = !in_rd && cnt != 0 && (!fifo.pop_valid || fifo.pop_ready);
            chk("stream_push_ready", 32'(fifo.push_ready), 32'(cnt < 64 && !rdi));
            in_rd = rdi;
            adv();
            if (pushed) np++;
        end
        chk("stream_pushed", 32'(np), 32'd200);
        fifo.push_valid = 1'b0;
        for (int i = 0; i < 400 && !empty; i++) cyc();
        chk("stream_left", 32'(sb.size()), 32'd0);

        // Reset while a read is in flight.
        fifo.pop_ready = 1'b0;
        fifo.push_valid = 1'b1; fifo.push_data = 8'h11;
        cyc();
        fifo.push_valid = 1'b0;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_pop_valid", 32'(fifo.pop_valid), 32'd0);
        chk("arst_pop_data", 32'(fifo.pop_data), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        fifo.push_valid = 1'b1; fifo.push_data = 8'h5A;
        cyc();
        fifo.push_valid = 1'b0;
        fifo.pop_ready = 1'b1;
        p0 = pops;
        for (int i = 0; i < 20 && pops == p0; i++) cyc();
        chk("arst_first_pop", 32'(pops), 32'(p0 + 1));
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
